// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

   localparam int IMEM_DATA_WIDTH = 32;
   localparam int IMEM_ADDR_WIDTH = 32;
   localparam int IMEM_DEPTH_LOG2 = 10;

   typedef struct packed {
      logic [IMEM_DATA_WIDTH-1:0] data;
      logic                       err;
   } imem_rsp_t;

   // True when a byte address is not word aligned or lies beyond the store.
   function automatic logic addr_bad(input logic [IMEM_ADDR_WIDTH-1:0] addr,
                                     input int unsigned               depth_log2);
      logic [IMEM_ADDR_WIDTH-1:0] hi;
      hi = addr >> (depth_log2 + 2);
      return (addr[1:0] != 2'b00) || (hi != '0);
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response FIFO; the head reads as zero while empty.
module resp_fifo
   import imem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  imem_rsp_t push_data,
   input  logic      pop,
   output imem_rsp_t head,
   output logic      empty,
   output logic      full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   imem_rsp_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: word store, fixed-latency read pipeline,
// in-order response FIFO and a credit counter that bounds outstanding fetches.
module imem_responder
   import imem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2,
   parameter int QDEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy
);

   localparam int CNT_W = $clog2(QDEPTH + 1);
   localparam int WORDS = 2 ** DEPTH_LOG2;

   if (QDEPTH < LATENCY + 1) begin : g_bad_qdepth
      $error("imem_responder: QDEPTH must be at least LATENCY+1");
   end
   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("imem_responder: LATENCY must be within 1..4");
   end
   if (DATA_WIDTH != IMEM_DATA_WIDTH || ADDR_WIDTH > IMEM_ADDR_WIDTH) begin : g_bad_width
      $error("imem_responder: widths must match the imem_pkg response type");
   end

   logic [DATA_WIDTH-1:0] store [WORDS];
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic                  req_err;
   logic                  wr_err;
   logic                  accept;
   logic                  pop;
   logic [CNT_W-1:0]      cnt;
   imem_rsp_t             rd_rsp;
   logic [LATENCY-1:0]    pipe_vld;
   imem_rsp_t             pipe_rsp [LATENCY];
   imem_rsp_t             fifo_head;
   logic                  fifo_empty;
   logic                  fifo_full;

   assign rd_idx  = req_addr[DEPTH_LOG2+1:2];
   assign wr_idx  = wr_addr[DEPTH_LOG2+1:2];
   assign req_err = addr_bad(IMEM_ADDR_WIDTH'(req_addr), DEPTH_LOG2);
   assign wr_err  = addr_bad(IMEM_ADDR_WIDTH'(wr_addr), DEPTH_LOG2);

   assign req_ready = (cnt < CNT_W'(QDEPTH));
   assign busy      = (cnt != '0);
   assign accept    = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;

   // Read happens in the accept cycle, ahead of any same-edge write.
   assign rd_rsp.data = req_err ? '0 : store[rd_idx];
   assign rd_rsp.err  = req_err;

   always_ff @(posedge clk) begin
      if (wr_en && !wr_err) store[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_rsp[i] <= '0;
      end else begin
         pipe_vld[0] <= accept;
         if (accept) pipe_rsp[0] <= rd_rsp;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_rsp[i] <= pipe_rsp[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   resp_fifo #(
      .DEPTH (QDEPTH)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pipe_vld[LATENCY-1]),
      .push_data (pipe_rsp[LATENCY-1]),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_data  = fifo_head.data;
   assign rsp_err   = fifo_head.err;

   // Credits cover every pipeline slot, so a push into a full FIFO cannot happen.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(fifo_full && pipe_vld[LATENCY-1] && !pop));

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder that answers fetch requests from the program-counter/fetch side using a valid/ready request and response handshake.
- It holds a word-addressed program store with a write-only load port for a testbench or boot loader.
- Reads pass through a fixed-latency read pipeline into an in-order response FIFO.
- A credit counter limits outstanding requests so that no response is ever dropped under back-pressure.

Parameters:
- DATA_WIDTH, 32, instruction/data word width.
- ADDR_WIDTH, 32, byte-address width of req_addr and wr_addr.
- DEPTH_LOG2, 10, log2 of the number of words in the store (1024 words).
- LATENCY, 2, read pipeline stages from acceptance to FIFO entry; legal range 1..4.
- QDEPTH, 4, maximum outstanding requests, which is also the response FIFO depth. Must be >= LATENCY+1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_WIDTH  byte address of the fetch.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_WIDTH  fetched word.
- rsp_err  out  1  request was misaligned or out of range.
- wr_en  in  1  load-port write strobe.
- wr_addr  in  ADDR_WIDTH  load-port byte address.
- wr_data  in  DATA_WIDTH  load-port word.
- busy  out  1  at least one request is outstanding.

Behaviour:
- Reset (rst low, asynchronous):
  - Pipeline valid bits cleared, FIFO emptied, credit count set to 0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, req_ready=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all in-flight and queued responses.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- Word index = req_addr[DEPTH_LOG2+1:2].
- Error detection, evaluated at acceptance:
  - req_addr[1:0] != 0 sets err=1.
  - req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] != 0 sets err=1.
  - On error, data=0.
- Read timing: the store is read in the accept cycle, so data is captured at acceptance. {data, err} then travel LATENCY pipeline stages.
- Latency: accepted at edge N means the FIFO entry is written at edge N+LATENCY. rsp_valid is high after edge N+LATENCY when the FIFO was empty.
- Credits:
  - count = pipeline entries + FIFO entries, width $clog2(QDEPTH+1).
  - +1 on accept, -1 on pop (rsp_valid && rsp_ready); both in one cycle leaves count unchanged.
  - req_ready = (count < QDEPTH). It is registered-free combinational from count, with no pass-through: at full, a pop enables acceptance on the next cycle only.
- The FIFO can never overflow by construction. Pipeline entries always find space.
- rsp_valid = FIFO not empty. rsp_data and rsp_err come from the FIFO head and are held stable while rsp_valid && !rsp_ready.
- Ordering: responses are returned strictly in acceptance order.
- Throughput: with rsp_ready held high, one request is accepted and one response is delivered per cycle, sustained.
- Load port:
  - wr_en writes wr_data to index wr_addr[DEPTH_LOG2+1:2] at the edge.
  - Misaligned or out-of-range wr_addr is silently ignored.
  - A write and an accepted read to the same word in one cycle: the read returns the old word (read-before-write).
- busy = (count != 0).
- req_addr is a don't-care when req_valid=0. A request held while req_ready=0 is not accepted and must be held by the requester.

Decomposition:
- Package imem_pkg:
  - Default width constants.
  - The typedef imem_rsp_t {logic [DATA_WIDTH-1:0] data; logic err;}.
  - A function that checks address alignment and range.
- Sub-module resp_fifo: a synchronous FIFO parameterised by depth and the imem_rsp_t payload, with push/pop/empty/full and the same clk/rst.
- The pipeline, store and credit counter stay in imem_responder.

Test Plan:
- Reset: assert rst=0 with 3 requests outstanding. Required: rsp_valid=0, busy=0 and req_ready=1 immediately; no stale response appears after release.
- Basic fetch, with LATENCY=2:
  - Load 0x00000013 at 0x0 and 0x00500093 at 0x4.
  - Accept 0x4 at edge N with rsp_ready=1.
  - Required: rsp_valid high after edge N+2 with rsp_data=0x00500093 and rsp_err=0.
- Back-pressure, with QDEPTH=4:
  - Hold rsp_ready=0 and issue 5 back-to-back requests to 0x0,0x4,0x8,0xC,0x10.
  - Required: 4 accepted, req_ready=0 after the 4th, 5th held.
  - Then raise rsp_ready. Required: responses arrive in order, and the 5th is accepted the cycle after the first pop.
- Errors:
  - req_addr=0x6 gives rsp_err=1 and rsp_data=0.
  - req_addr=0x1000 (DEPTH_LOG2=10) gives rsp_err=1.
  - The next request, 0x0, gives rsp_err=0.
- Collision:
  - Word 0x8 holds 0xAAAAAAAA. Write 0xBBBBBBBB to 0x8 in the same cycle that a read of 0x8 is accepted.
  - Required: that response is 0xAAAAAAAA, and a following read returns 0xBBBBBBBB.
- Streaming: hold rsp_ready=1 and req_valid=1 for 16 sequential addresses. Required: 16 responses on 16 consecutive cycles starting at latency 2, req_ready constantly 1.
